// File: rtl/sm_pkg.sv
// Shared types and constants for the stepper-motor step driver.
`timescale 1ns/1ps
package sm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIR_SETUP = 2'd1,
    ST_STEP_HIGH = 2'd2,
    ST_STEP_LOW  = 2'd3
  } sm_state_e;

  localparam int SM_W_POS = 32;
  localparam int SM_TMR_W = 16;

endpackage

// File: rtl/sm_timer.sv
// Loadable down-counter; done_o is high whenever the count has reached zero.
`timescale 1ns/1ps
module sm_timer
  import sm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [SM_TMR_W-1:0] load_val_i,
  output logic                done_o
);

  logic [SM_TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/sm_step_driver.sv
// Step/dir driver: shapes one-cycle step requests into timed pulses with
// direction setup, a one-deep request buffer and soft position limits.
`timescale 1ns/1ps
module sm_step_driver
  import sm_pkg::*;
#(
  parameter int T_HIGH      = 4,
  parameter int T_LOW       = 4,
  parameter int T_DIR_SETUP = 10,
  parameter int POS_MIN     = -100000,
  parameter int POS_MAX     = 100000,
  parameter int W_POS       = SM_W_POS
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drv_step,
  input  logic                    drv_dir,
  input  logic                    drv_enable_SM,
  output logic                    step_out,
  output logic                    dir_out,
  output logic                    ena_n,
  output logic signed [W_POS-1:0] position,
  output logic                    busy,
  output logic                    overrun,
  output logic                    limit_hit
);

  localparam logic signed [W_POS-1:0] POS_MIN_C = W_POS'(POS_MIN);
  localparam logic signed [W_POS-1:0] POS_MAX_C = W_POS'(POS_MAX);
  localparam logic signed [W_POS-1:0] POS_ONE   = {{(W_POS-1){1'b0}}, 1'b1};

  sm_state_e               state_q, state_d;
  logic                    dir_q, dir_d;
  logic                    step_q;
  logic                    ena_n_q, ena_n_d;
  logic                    pend_v_q, pend_v_d;
  logic                    pend_dir_q, pend_dir_d;
  logic                    ovr_q, ovr_d;
  logic                    lim_q, lim_d;
  logic signed [W_POS-1:0] pos_q, pos_d;

  logic                    req;
  logic                    serve_pt;
  logic                    serve_en;
  logic                    serve_dir;
  logic                    direct;
  logic                    consumed;
  logic                    tmr_load;
  logic                    tmr_done;
  logic [SM_TMR_W-1:0]     tmr_val;

  function automatic logic in_limits(input logic signed [W_POS-1:0] pos, input logic dir);
    if (dir) return pos < POS_MAX_C;
    return pos > POS_MIN_C;
  endfunction

  assign req      = drv_step & drv_enable_SM;
  // Decision point: idle, or the last STEP_LOW cycle (back-to-back pulses skip IDLE)
  assign serve_pt = (state_q == ST_IDLE) || ((state_q == ST_STEP_LOW) && tmr_done);

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pos_d      = pos_q;
    pend_v_d   = pend_v_q;
    pend_dir_d = pend_dir_q;
    ovr_d      = ovr_q;
    lim_d      = 1'b0;
    serve_en   = 1'b0;
    serve_dir  = dir_q;
    direct     = 1'b0;
    consumed   = 1'b0;

    case (state_q)
      ST_DIR_SETUP: begin
        if (!drv_enable_SM) state_d = ST_IDLE;
        else if (tmr_done)  state_d = ST_STEP_HIGH;
      end
      ST_STEP_HIGH: begin
        if (tmr_done) begin
          state_d = ST_STEP_LOW;
          pos_d   = dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
        end
      end
      default: ;
    endcase

    if (serve_pt) begin
      if (!drv_enable_SM) begin
        state_d = ST_IDLE;
      end else if (pend_v_q) begin
        serve_en  = 1'b1;
        serve_dir = pend_dir_q;
        consumed  = 1'b1;
      end else if (req) begin
        serve_en  = 1'b1;
        serve_dir = drv_dir;
        direct    = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (serve_en) begin
      if (!in_limits(pos_q, serve_dir)) begin
        lim_d   = 1'b1;
        state_d = ST_IDLE;
      end else if (serve_dir == dir_q) begin
        state_d = ST_STEP_HIGH;
      end else begin
        dir_d   = serve_dir;
        state_d = ST_DIR_SETUP;
      end
    end

    if (consumed) pend_v_d = 1'b0;

    // A request not served directly goes to the slot, which may have just been freed
    if (req && !direct) begin
      if (pend_v_q && !consumed) begin
        ovr_d = 1'b1;
      end else if (!in_limits(pos_q, drv_dir)) begin
        lim_d = 1'b1;
      end else begin
        pend_v_d   = 1'b1;
        pend_dir_d = drv_dir;
      end
    end

    if (!drv_enable_SM) begin
      pend_v_d = 1'b0;
      ovr_d    = 1'b0;
    end

    ena_n_d = drv_enable_SM ? 1'b0 : ((state_d == ST_IDLE) ? 1'b1 : ena_n_q);
  end

  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_DIR_SETUP: tmr_val = SM_TMR_W'(T_DIR_SETUP - 1);
      ST_STEP_HIGH: tmr_val = SM_TMR_W'(T_HIGH - 1);
      ST_STEP_LOW:  tmr_val = SM_TMR_W'(T_LOW - 1);
      default:      tmr_val = '0;
    endcase
  end

  sm_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b1;
      step_q     <= 1'b0;
      ena_n_q    <= 1'b1;
      pend_v_q   <= 1'b0;
      pend_dir_q <= 1'b0;
      ovr_q      <= 1'b0;
      lim_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      step_q     <= (state_d == ST_STEP_HIGH);
      ena_n_q    <= ena_n_d;
      pend_v_q   <= pend_v_d;
      pend_dir_q <= pend_dir_d;
      ovr_q      <= ovr_d;
      lim_q      <= lim_d;
      pos_q      <= pos_d;
    end
  end

  assign step_out  = step_q;
  assign dir_out   = dir_q;
  assign ena_n     = ena_n_q;
  assign position  = pos_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = ovr_q;
  assign limit_hit = lim_q;

endmodule

// File: tb/tb_sm_step_driver.sv
// Scoreboard bench for sm_step_driver: a timing-level model predicts each
// pulse and limit event; a monitor checks what the DUT actually emits.
`timescale 1ns/1ps
module tb_sm_step_driver;

  localparam int T_HIGH = 4;
  localparam int T_LOW  = 4;
  localparam int T_DIR  = 10;
  localparam int PMIN   = -3;
  localparam int PMAX   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drv_step = 1'b0;
  logic drv_dir = 1'b0;
  logic en = 1'b0;
  logic step_out, dir_out, ena_n, busy, overrun, limit_hit;
  logic signed [31:0] position;

  sm_step_driver #(
    .T_HIGH(T_HIGH), .T_LOW(T_LOW), .T_DIR_SETUP(T_DIR),
    .POS_MIN(PMIN), .POS_MAX(PMAX), .W_POS(32)
  ) dut (
    .clk(clk), .rst(rst), .drv_step(drv_step), .drv_dir(drv_dir),
    .drv_enable_SM(en), .step_out(step_out), .dir_out(dir_out), .ena_n(ena_n),
    .position(position), .busy(busy), .overrun(overrun), .limit_hit(limit_hit)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   rise;
    logic dir;
    int   pos;
  } pulse_t;

  pulse_t exp_q[$];
  int     lim_q[$];
  int     n_tests = 0;
  int     n_fail = 0;
  int     n_pulses = 0;
  int     n_lims = 0;
  bit     mon_en = 1'b1;

  // Reference model: time-stamped schedule of decisions, pulses and position
  int   m_pos, m_pos_old, m_upd_at, m_serve_at;
  logic m_dir, m_pend, m_pend_dir, m_ovr;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_ok(input int p, input logic d);
    return d ? (p < PMAX) : (p > PMIN);
  endfunction

  function automatic int pos_now(input int c);
    return (c >= m_upd_at) ? m_pos : m_pos_old;
  endfunction

  task automatic m_reset();
    m_pos = 0; m_pos_old = 0; m_upd_at = 0; m_serve_at = 0;
    m_dir = 1'b1; m_pend = 1'b0; m_pend_dir = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic push_lim(input int c);
    if (lim_q.size() == 0 || lim_q[lim_q.size()-1] != c) lim_q.push_back(c);
  endtask

  task automatic m_decide(input int c, input logic d);
    int p;
    int r;
    pulse_t e;
    p = pos_now(c);
    if (!m_ok(p, d)) begin
      push_lim(c + 1);
      m_serve_at = c + 1;
    end else begin
      r = c + 1 + ((d != m_dir) ? T_DIR : 0);
      m_dir = d;
      m_pos_old = p;
      m_pos = p + (d ? 1 : -1);
      m_upd_at = r + T_HIGH;
      e.rise = r; e.dir = d; e.pos = m_pos;
      exp_q.push_back(e);
      m_serve_at = r + T_HIGH + T_LOW - 1;
    end
  endtask

  task automatic m_intake(input int c, input logic d);
    if (m_pend) m_ovr = 1'b1;
    else if (!m_ok(pos_now(c), d)) push_lim(c + 1);
    else begin
      m_pend = 1'b1;
      m_pend_dir = d;
    end
  endtask

  task automatic m_cycle(input int c, input logic s, input logic d, input logic e);
    logic pd;
    if (!e) begin
      m_pend = 1'b0;
      m_ovr = 1'b0;
    end else if (c >= m_serve_at) begin
      if (m_pend) begin
        pd = m_pend_dir;
        m_pend = 1'b0;
        if (s) m_intake(c, d);
        m_decide(c, pd);
      end else if (s) begin
        m_decide(c, d);
      end
    end else if (s) begin
      m_intake(c, d);
    end
  endtask

  task automatic drive(input logic s, input logic d, input logic e);
    @(posedge clk);
    #1;
    drv_step = s;
    drv_dir  = d;
    en       = e;
    m_cycle(cyc, s, d, e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; drv_step = 1'b0; en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    lim_q.delete();
    m_reset();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input logic e);
    int guard;
    guard = 0;
    while ((cyc <= m_serve_at + 1 || m_pend) && guard < 500) begin
      drive(1'b0, 1'b0, e);
      guard++;
    end
    check({tag, "_drain_in_time"}, guard < 500, 1);
    drive(1'b0, 1'b0, e);
    drive(1'b0, 1'b0, e);
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_position"}, position, m_pos);
    check({tag, "_overrun"}, overrun, m_ovr);
    check({tag, "_pulses_left"}, exp_q.size(), 0);
    check({tag, "_limits_left"}, lim_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT emits a pulse or limit_hit
  initial begin
    int     fall_c;
    int     hi;
    logic   pdir;
    logic   prev;
    logic   dchg;
    bit     have;
    pulse_t cur;
    fall_c = -1000; hi = 0; pdir = 1'b0; prev = 1'b0; dchg = 1'b0; have = 1'b0;
    cur.rise = 0; cur.dir = 1'b0; cur.pos = 0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        prev = 1'b0; hi = 0; have = 1'b0; fall_c = -1000;
        continue;
      end
      if (step_out && !prev) begin
        n_pulses++;
        check("pulse_low_gap_ok", (cyc - fall_c) >= T_LOW, 1);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: rise at cycle %0d, none expected", cyc);
          have = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          have = 1'b1;
          check("pulse_rise_cycle", cyc, cur.rise);
          check("pulse_dir", dir_out, cur.dir);
        end
        hi = 0; pdir = dir_out; dchg = 1'b0;
      end
      if (step_out) begin
        hi++;
        if (dir_out != pdir) dchg = 1'b1;
      end
      if (!step_out && prev) begin
        fall_c = cyc;
        check("pulse_high_width", hi, T_HIGH);
        check("dir_stable_in_pulse", dchg, 0);
        if (have) check("pulse_position", position, cur.pos);
      end
      if (limit_hit) begin
        n_lims++;
        if (lim_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_limit_hit: at cycle %0d, none expected", cyc);
        end else begin
          check("limit_hit_cycle", cyc, lim_q.pop_front());
        end
      end
      prev = step_out;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_step_out"}, step_out, 0);
    check({tag, "_dir_out"}, dir_out, 1);
    check({tag, "_ena_n"}, ena_n, 1);
    check({tag, "_position"}, position, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_limit_hit"}, limit_hit, 0);
  endtask

  initial begin
    int c0;
    m_reset();
    do_reset();
    check_reset_vals("rst");

    // Enable rising reaches ena_n in one cycle
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    check("ena_n_on_enable", ena_n, 0);

    // Single positive step: high cycles 1..4, low 5..8, idle at 9
    drive(1'b1, 1'b1, 1'b1);
    c0 = cyc;
    repeat (8) drive(1'b0, 1'b0, 1'b1);
    check("single_busy_c8", busy, 1);
    drive(1'b0, 1'b0, 1'b1);
    check("single_busy_c9", busy, 0);
    check("single_position", position, 1);
    drain("single", 1'b1);

    // Reset in the middle of STEP_HIGH
    mon_en = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    check("rst_mid_step_high", step_out, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("rst_mid_pulse");
    do_reset();
    mon_en = 1'b1;

    // Direction change: dir_out flips next cycle, pulse 10 cycles after that
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    c0 = cyc;
    drive(1'b0, 1'b0, 1'b1);
    check("dirchg_dir_out", dir_out, 0);
    repeat (9) drive(1'b0, 1'b0, 1'b1);
    check("dirchg_step_c10", step_out, 0);
    drive(1'b0, 1'b0, 1'b1);
    check("dirchg_step_c11", step_out, 1);
    drain("dirchg", 1'b1);
    check("dirchg_position", position, -1);

    // Three back-to-back requests: two pulses and overrun
    do_reset();
    drive(1'b0, 1'b0, 1'b1);
    n_pulses = 0;
    repeat (3) drive(1'b1, 1'b1, 1'b1);
    drain("burst", 1'b1);
    check("burst_pulses", n_pulses, 2);
    check("burst_overrun", overrun, 1);
    check("burst_position", position, 2);

    // Upper soft limit at 2: five spaced requests
    do_reset();
    drive(1'b0, 1'b0, 1'b1);
    n_pulses = 0;
    n_lims = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      repeat (11) drive(1'b0, 1'b0, 1'b1);
    end
    drain("limit", 1'b1);
    check("limit_pulses", n_pulses, 2);
    check("limit_hits", n_lims, 3);
    check("limit_position", position, 2);

    // Enable dropped in 2nd STEP_HIGH cycle with a request pending
    do_reset();
    drive(1'b0, 1'b0, 1'b1);
    n_pulses = 0;
    drive(1'b1, 1'b1, 1'b1);
    c0 = cyc;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    check("endrop_busy_c6", busy, 1);
    check("endrop_ena_n_c6", ena_n, 0);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    check("endrop_busy_c9", busy, 0);
    check("endrop_ena_n_c9", ena_n, 1);
    drain("endrop", 1'b0);
    check("endrop_pulses", n_pulses, 1);

    // Randomized traffic against the model
    do_reset();
    drive(1'b0, 1'b0, 1'b1);
    for (int seg = 0; seg < 3; seg++) begin
      for (int i = 0; i < 250; i++) begin
        drive(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      end
      drain("rand", 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      check("rand_overrun_cleared", overrun, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_step_driver.md
SM_STEP_DRIVER -- requirements
Module: sm_step_driver

Interface
REQ-001 SHALL have parameter T_HIGH, default 4, minimum step_out high width in clk cycles (>=1).
REQ-002 SHALL have parameter T_LOW, default 4, minimum step_out low width after each pulse in clk cycles (>=1).
REQ-003 SHALL have parameter T_DIR_SETUP, default 10, cycles dir_out is stable before the following step_out rise (>=1).
REQ-004 SHALL have parameters POS_MIN, default -100000, and POS_MAX, default 100000: signed soft limits, POS_MIN < POS_MAX.
REQ-005 SHALL have parameter W_POS, default 32, width of the position counter.
REQ-006 SHALL have port clk  input  1  system clock (50 MHz); single clock domain.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port drv_step  input  1  one-cycle step request from the step pulse generator.
REQ-009 SHALL have port drv_dir  input  1  requested direction (1 = positive), sampled with drv_step.
REQ-010 SHALL have port drv_enable_SM  input  1  motor enable from the tracking controller.
REQ-011 SHALL have ports step_out, dir_out, ena_n  output  1 each  driver pins; ena_n is active-low.
REQ-012 SHALL have port position  output  W_POS  signed absolute step count.
REQ-013 SHALL have ports busy, overrun, limit_hit  output  1 each  status flags.

Function
REQ-014 SHALL implement FSM states IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW; busy = (state != IDLE).
REQ-015 SHALL accept a request only when drv_step=1 and drv_enable_SM=1; otherwise ignore it.
REQ-016 SHALL, in IDLE, accept a request to STEP_HIGH next cycle when drv_dir == dir_out (step_out rises at cycle n+1), else to DIR_SETUP.
REQ-017 SHALL, on entering DIR_SETUP, drive dir_out = requested dir, hold T_DIR_SETUP cycles, then enter STEP_HIGH.
REQ-018 SHALL hold step_out=1 for exactly T_HIGH cycles in STEP_HIGH, then step_out=0 for exactly T_LOW cycles in STEP_LOW.
REQ-019 SHALL update position by +1 (dir_out=1) or -1 (dir_out=0) in the cycle STEP_HIGH exits to STEP_LOW.
REQ-020 SHALL store one request (step + dir) in a one-deep pending slot while busy; when STEP_LOW ends, a pending request is served as from IDLE (no IDLE cycle), else FSM returns to IDLE.
REQ-021 SHALL, when a request arrives in the same cycle the pending slot is consumed, store it in the freed slot.
REQ-022 SHALL drop a request arriving with the slot full and set overrun (sticky until rst, or drv_enable_SM=0).
REQ-023 SHALL reject a request that would move position above POS_MAX or below POS_MIN: no pulse, no dir change, limit_hit high one cycle; evaluated at acceptance and again when a pending request is served.
REQ-024 SHALL drive ena_n=0 within one cycle of drv_enable_SM rising.
REQ-025 SHALL, on drv_enable_SM falling mid-pulse, finish the current STEP_HIGH/STEP_LOW unshortened, clear pending, abort DIR_SETUP to IDLE without pulsing, and drive ena_n=1 only once in IDLE.
REQ-026 SHALL never produce step_out high or low runs shorter than T_HIGH / T_LOW, nor change dir_out while step_out=1 or in STEP_LOW.

Reset
REQ-027 SHALL on rst set: state IDLE, step_out 0, dir_out 1, ena_n 1, position 0, busy 0, overrun 0, limit_hit 0, pending empty, timers 0.
REQ-028 SHALL let rst override any operation in progress, including an active step pulse (truncation permitted only under reset).

Structure
REQ-029 SHALL place the FSM state enum, W_POS default and the timer width constant in shared package sm_pkg.
REQ-030 SHALL use one sub-module sm_timer (loadable down-counter with done flag) for all three state delays.

Verification
REQ-031 SHALL test: enable=1, one request dir=1 at cycle 0 after reset -> step_out high cycles 1..4, low 5..8, position=1, busy low at cycle 9.
REQ-032 SHALL test: dir_out=1, request dir=0 -> dir_out=0 next cycle, step_out rises 10 cycles later, position decrements by 1.
REQ-033 SHALL test: three requests on consecutive cycles -> exactly two pulses, overrun=1, position=2.
REQ-034 SHALL test: POS_MAX=2, five spaced dir=1 requests -> two pulses, position=2, three limit_hit pulses.
REQ-035 SHALL test: drv_enable_SM dropped at 2nd cycle of STEP_HIGH with a pending request -> pulse still 4 cycles high, pending discarded, ena_n=1 after return to IDLE.
REQ-036 SHALL test: rst asserted during STEP_HIGH -> next cycle all outputs at reset values, position=0.
